mem_arbiter: RTL and testbench

- Sits between the L1 caches (i_cache, d_cache) and the shared lower-level memory port (L2/pmem).
- Accepts cacheline read requests from the I-cache and cacheline read/write requests from the D-cache.
- Serialises them onto a single L2 port with round-robin fairness.
- Returns the L2 response to whichever cache was granted.

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client cacheline arbiter: serialises I-cache reads and D-cache reads/write-backs
// onto one L2 port with round-robin fairness and returns the L2 response to the grantee.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_e;

  state_e              state_q;
  grant_e              grantee_q;
  grant_e              last_grant_q;
  logic                l2_read_q;
  logic                l2_write_q;
  logic [ADDR_W-1:0]   l2_addr_q;
  logic [LINE_W-1:0]   l2_wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                i_resp_q;
  logic                d_resp_q;

  logic                d_pend;
  logic                any_pend;
  grant_e              grant_d;

  // Only one side pending wins outright; a tie goes to the side not served last.
  always_comb begin
    d_pend   = d_read | d_write;
    any_pend = i_read | d_pend;
    grant_d  = GRANT_D;
    if (i_read && d_pend) begin
      grant_d = (last_grant_q == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (i_read) begin
      grant_d = GRANT_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grantee_q    <= GRANT_D;
      last_grant_q <= GRANT_D;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      rdata_q      <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_pend) begin
            grantee_q    <= grant_d;
            last_grant_q <= grant_d;
            state_q      <= BUSY;
            if (grant_d == GRANT_I) begin
              l2_read_q  <= 1'b1;
              l2_write_q <= 1'b0;
              l2_addr_q  <= i_addr;
              l2_wdata_q <= '0;
            end else begin
              // A write request dominates; read+write together is issued as a write.
              l2_read_q  <= ~d_write;
              l2_write_q <= d_write;
              l2_addr_q  <= d_addr;
              l2_wdata_q <= d_wdata;
            end
          end
        end
        BUSY: begin
          if (l2_resp) begin
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            if (l2_read_q) begin
              rdata_q <= l2_rdata;
            end
            if (grantee_q == GRANT_I) begin
              i_resp_q <= 1'b1;
            end else begin
              d_resp_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign l2_addr  = l2_addr_q;
  assign l2_wdata = l2_wdata_q;
  assign i_rdata  = rdata_q;
  assign d_rdata  = rdata_q;
  assign i_resp   = i_resp_q;
  assign d_resp   = d_resp_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions, directed corner sequences,
// then random traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata = '0;
  logic          l2_resp = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  typedef struct {
    logic          ir;
    logic          dr;
    logic          dw;
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    logic [LW-1:0] dwd;
    int            lat;
    logic [LW-1:0] rd;
    logic          exp_d;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
    logic [LW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_l2_read"}, l2_read, 1'b0);
    chk1({tag, "_l2_write"}, l2_write, 1'b0);
    chka({tag, "_l2_addr"}, l2_addr, '0);
    chkd({tag, "_l2_wdata"}, l2_wdata, '0);
    chkd({tag, "_i_rdata"}, i_rdata, '0);
    chkd({tag, "_d_rdata"}, d_rdata, '0);
    chk1({tag, "_i_resp"}, i_resp, 1'b0);
    chk1({tag, "_d_resp"}, d_resp, 1'b0);
  endtask

  // Called from a just-after-edge point with DUT idle; ends with DUT idle.
  task automatic do_reset();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    #9 rst_n = 1'b1;
    tick();
  endtask

  // Requests are already driven; the next edge samples them. The grantee holds its
  // request through the resp cycle and drops it one cycle later.
  task automatic expect_txn(input logic who_d, input logic wr, input logic [AW-1:0] addr,
                            input logic [LW-1:0] wdata, input int lat,
                            input logic [LW-1:0] rd, input logic [LW-1:0] exp_rd);
    chk1("pre_l2_read", l2_read, 1'b0);
    chk1("pre_l2_write", l2_write, 1'b0);
    tick();
    for (int c = 1; c <= lat; c++) begin
      chk1("busy_l2_read", l2_read, !wr);
      chk1("busy_l2_write", l2_write, wr);
      chka("busy_l2_addr", l2_addr, addr);
      chkd("busy_l2_wdata", l2_wdata, wdata);
      chk1("busy_no_resp", i_resp | d_resp, 1'b0);
      if (c == lat) begin
        l2_resp  = 1'b1;
        l2_rdata = rd;
      end
      tick();
    end
    l2_resp = 1'b0;
    chk1("resp_i", i_resp, !who_d);
    chk1("resp_d", d_resp, who_d);
    chk1("resp_l2_idle", l2_read | l2_write, 1'b0);
    chkd("resp_i_rdata", i_rdata, exp_rd);
    chkd("resp_d_rdata", d_rdata, exp_rd);
    tick();
    chk1("pulse_i", i_resp, 1'b0);
    chk1("pulse_d", d_resp, 1'b0);
    if (who_d) begin
      d_read = 1'b0; d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  function automatic vec_t mk(input logic ir, dr, dw, input logic [AW-1:0] ia, da,
                              input logic [LW-1:0] dwd, input int lat, input logic [LW-1:0] rd,
                              input logic exp_d, exp_wr, input logic [AW-1:0] exp_addr,
                              input logic [LW-1:0] exp_wdata, exp_rdata);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.dwd = dwd;
    v.lat = lat; v.rd = rd; v.exp_d = exp_d; v.exp_wr = exp_wr;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          m_busy, m_who, m_wr, m_last, gap, real_resp, completed;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata, m_rdata;
    int            lat;

    vecs[0] = mk(1, 0, 0, 32'h60, 32'h0, '0, 3, {8{32'hAAAA_AAAA}},
                 0, 0, 32'h60, '0, {8{32'hAAAA_AAAA}});
    vecs[1] = mk(0, 0, 1, 32'h0, 32'h264, {8{32'h1234_5678}}, 5, {8{32'hDEAD_BEEF}},
                 1, 1, 32'h264, {8{32'h1234_5678}}, {8{32'hAAAA_AAAA}});
    vecs[2] = mk(0, 1, 0, 32'h0, 32'h80, {8{32'h0F0F_0F0F}}, 2, {8{32'h5555_5555}},
                 1, 0, 32'h80, {8{32'h0F0F_0F0F}}, {8{32'h5555_5555}});
    vecs[3] = mk(0, 1, 1, 32'h0, 32'h300, {8{32'hC3C3_C3C3}}, 1, {8{32'hFFFF_0000}},
                 1, 1, 32'h300, {8{32'hC3C3_C3C3}}, {8{32'h5555_5555}});
    vecs[4] = mk(1, 0, 0, 32'h1C0, 32'h0, '0, 4, {8{32'h0123_4567}},
                 0, 0, 32'h1C0, '0, {8{32'h0123_4567}});

    @(posedge clk);
    #1;
    do_reset();

    for (int v = 0; v < 5; v++) begin
      i_read = vecs[v].ir; i_addr = vecs[v].ia;
      d_read = vecs[v].dr; d_write = vecs[v].dw; d_addr = vecs[v].da; d_wdata = vecs[v].dwd;
      expect_txn(vecs[v].exp_d, vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].exp_wdata,
                 vecs[v].lat, vecs[v].rd, vecs[v].exp_rdata);
      tick();
      chk1("no_reissue", l2_read | l2_write, 1'b0);
    end

    // Simultaneous requests: fresh reset favours I, then D; after an I-only
    // transaction the next tie favours D.
    do_reset();
    i_read = 1'b1; i_addr = 32'h100;
    d_read = 1'b1; d_addr = 32'h200; d_wdata = {8{32'h7777_0000}};
    expect_txn(0, 0, 32'h100, '0, 2, {8{32'h1111_1111}}, {8{32'h1111_1111}});
    expect_txn(1, 0, 32'h200, {8{32'h7777_0000}}, 3, {8{32'h2222_2222}}, {8{32'h2222_2222}});
    i_read = 1'b1; i_addr = 32'h140;
    expect_txn(0, 0, 32'h140, '0, 1, {8{32'h3333_3333}}, {8{32'h3333_3333}});
    i_read = 1'b1; i_addr = 32'h180;
    d_write = 1'b1; d_addr = 32'h240; d_wdata = {8{32'h9999_AAAA}};
    expect_txn(1, 1, 32'h240, {8{32'h9999_AAAA}}, 2, {8{32'h4444_4444}}, {8{32'h3333_3333}});
    expect_txn(0, 0, 32'h180, '0, 1, {8{32'h5151_5151}}, {8{32'h5151_5151}});
    tick();
    chk1("pair_done_idle", l2_read | l2_write, 1'b0);

    // Reset asserted mid-transaction drops it without a response.
    d_read = 1'b1; d_addr = 32'h40;
    tick();
    chk1("midrst_busy", l2_read, 1'b1);
    tick();
    l2_resp = 1'b1; l2_rdata = {8{32'hBAD0_BAD0}};
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    d_read = 1'b0; l2_resp = 1'b0;
    #4 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("midrst_no_i_resp", i_resp, 1'b0);
      chk1("midrst_no_d_resp", d_resp, 1'b0);
      chk1("midrst_l2_idle", l2_read | l2_write, 1'b0);
    end
    d_read = 1'b1; d_addr = 32'h80; d_wdata = {8{32'h6666_6666}};
    expect_txn(1, 0, 32'h80, {8{32'h6666_6666}}, 2, {8{32'h8888_8888}}, {8{32'h8888_8888}});
    tick();

    // Spurious l2_resp in IDLE is ignored and does not disturb the next request.
    l2_resp = 1'b1; l2_rdata = {8{32'hFEED_FACE}};
    tick();
    l2_resp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk1("spur_i_resp", i_resp, 1'b0);
      chk1("spur_d_resp", d_resp, 1'b0);
      chk1("spur_l2_idle", l2_read | l2_write, 1'b0);
      chkd("spur_rdata", i_rdata, {8{32'h8888_8888}});
      tick();
    end
    i_read = 1'b1; i_addr = 32'h20;
    expect_txn(0, 0, 32'h20, '0, 1, {8{32'hABCD_0123}}, {8{32'hABCD_0123}});
    tick();

    // Random traffic against a transaction-level model of the arbitration rules.
    do_reset();
    m_busy = 1'b0; m_who = 1'b0; m_wr = 1'b0; m_last = 1'b1; gap = 1'b0;
    real_resp = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      completed = m_busy && real_resp;
      chk1("rnd_i_resp", i_resp, completed && !m_who);
      chk1("rnd_d_resp", d_resp, completed && m_who);
      l2_resp = 1'b0;
      real_resp = 1'b0;
      if (completed) begin
        if (!m_wr) m_rdata = l2_rdata;
        chk1("rnd_resp_l2_idle", l2_read | l2_write, 1'b0);
        m_busy = 1'b0;
        gap = 1'b1;
        if (m_who) begin
          d_read = 1'b0; d_write = 1'b0;
        end else begin
          i_read = 1'b0;
        end
      end else if (gap) begin
        gap = 1'b0;
        chk1("rnd_gap_l2_idle", l2_read | l2_write, 1'b0);
      end else if (!m_busy) begin
        if (i_read || d_read || d_write) begin
          if (i_read && (d_read || d_write)) m_who = !m_last;
          else m_who = !i_read;
          m_last  = m_who;
          m_wr    = m_who && d_write;
          m_addr  = m_who ? d_addr : i_addr;
          m_wdata = m_who ? d_wdata : '0;
          m_busy  = 1'b1;
          lat     = $urandom_range(0, 3);
        end else begin
          chk1("rnd_idle_l2_idle", l2_read | l2_write, 1'b0);
        end
      end
      if (m_busy) begin
        chk1("rnd_l2_read", l2_read, !m_wr);
        chk1("rnd_l2_write", l2_write, m_wr);
        chka("rnd_l2_addr", l2_addr, m_addr);
        chkd("rnd_l2_wdata", l2_wdata, m_wdata);
        if (lat == 0) begin
          l2_resp = 1'b1; real_resp = 1'b1; l2_rdata = {8{$urandom}};
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        l2_resp = 1'b1; l2_rdata = {8{$urandom}};
      end
      chkd("rnd_i_rdata", i_rdata, m_rdata);
      chkd("rnd_d_rdata", d_rdata, m_rdata);
      if (!i_read && $urandom_range(0, 2) == 0) begin
        i_read = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFE0;
      end
      if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: d_read = 1'b1;
          1: d_write = 1'b1;
          default: begin
            d_read = 1'b1; d_write = 1'b1;
          end
        endcase
        d_addr  = $urandom & 32'hFFFF_FFE0;
        d_wdata = {8{$urandom}};
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
